mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single data-memory/I/O access port of the MEM stage between two requesters. Port A is the pipeline LSU; port B is the debug/program-loader port. The block sits between both requesters and the DMEM + I/O-buffer address decode. It issues one access per cycle and routes synchronous read data back to the owner, tagged by issue order. It also produces the pipeline stall when the LSU is not granted, and guarantees that port B cannot be starved.

## Interface
- `STARVE_LIMIT`, default 4: consecutive A-grants tolerated while B waits; legal range 1..15.
- `RD_LATENCY`, default 1: downstream read latency in cycles; legal range 1..4.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: reset, synchronous, active-low.
- `i_a_req` in 1: LSU access request (already gated valid & ~bubble & ~kill upstream).
- `i_a_we` in 1: LSU write (1) / read (0).
- `i_a_addr` in 32: LSU byte address.
- `i_a_wdata` in 32: LSU write data, lane-replicated.
- `i_a_be` in 4: LSU byte enables.
- `o_a_gnt` in→out 1: LSU access issued this cycle.
- `o_a_rvalid` out 1: LSU read data valid.
- `o_a_rdata` out 32: LSU read data.
- `i_b_req`, `i_b_we`, `i_b_addr`[32], `i_b_wdata`[32], `i_b_be`[4]: port-B equivalents.
- `i_b_lock` in 1: port B requests exclusive ownership.
- `o_b_gnt`, `o_b_rvalid`, `o_b_rdata`[32]: port-B equivalents.
- `o_m_req` out 1: downstream access strobe.
- `o_m_we` out 1: downstream write.
- `o_m_addr` out 32: downstream address.
- `o_m_wdata` out 32: downstream write data.
- `o_m_be` out 4: downstream byte enables; forced to 0 when `o_m_we` = 0.
- `i_m_rdata` in 32: downstream read data, valid `RD_LATENCY` cycles after the issue cycle.
- `o_lsu_stall` out 1: equals `i_a_req & ~o_a_gnt`.
- `o_locked` out 1: FSM is in LOCK_B.

## Operation
- **Grant decision.** Combinational from the requests and the registered state. At most one of `o_a_gnt`/`o_b_gnt` is high in any cycle. The granted port's fields are muxed onto `o_m_*`, and `o_m_req` = grant.
- **FSM states: ARB, LOCK_B.**
  - In ARB, port A has priority. The exception is when B is requesting and `starve_cnt` == `STARVE_LIMIT`; then B wins that cycle.
  - In LOCK_B, only B may be granted. A is stalled.
- **ARB → LOCK_B.** Taken at the next edge after a cycle with `o_b_gnt` & `i_b_lock`.
- **LOCK_B → ARB.** Taken at the next edge after a cycle in LOCK_B with `i_b_lock` = 0. B still has exclusive priority in that exit cycle.
- **`starve_cnt` rules.** Width 4, updated in ARB only.
  - Increments when `o_a_gnt` & `i_b_req`.
  - Clears when `o_b_gnt`, or when `i_b_req` = 0.
  - Saturates at `STARVE_LIMIT`.
  - Held in LOCK_B.
- **Requester handshake.** A requester holds req and all fields stable until it sees its gnt. A request withdrawn before gnt is legal and has no effect.
- **Read tag pipeline.** A shift register `RD_LATENCY` deep; each entry is {valid, owner}.
  - An entry is pushed every cycle; valid = `o_m_req` & ~`o_m_we`.
  - At the tail, `o_x_rvalid` = tail.valid & (tail.owner == x).
  - `o_x_rdata` = `i_m_rdata` when `o_x_rvalid`, otherwise 32'h0.
- **Writes** produce no response.
- **Back-to-back reads** from mixed owners return in issue order, one per cycle.

## Timing
- Grant has zero latency: it is asserted in the request cycle.
- Read response arrives exactly `RD_LATENCY` cycles after the grant cycle.
- Throughput is one access per cycle, with no dead cycle between owners.
- **Reset values:**
  - FSM = ARB, `starve_cnt` = 0, all tag entries invalid.
  - While `i_reset` = 0, all grants, `o_m_req`, rvalids and `o_lsu_stall` are 0, and rdata is 0.
- **Reset mid-operation.** In-flight read responses are discarded; no rvalid is produced after reset for an earlier issue. A lock held at reset is released.
- **Simultaneous requests** with `starve_cnt` < `STARVE_LIMIT` → A is granted.
- **`i_b_lock` without `i_b_req`** has no effect in ARB.
- **Lock held with `i_b_req` = 0** → no grants are issued, and A stays stalled.

## Structure
- **Shared package `mem_arb_pkg`:**
  - `owner_e` enum (OWN_A, OWN_B).
  - `arb_state_e` enum (ARB, LOCK_B).
  - `rd_tag_t` struct {valid, owner}.
  - Limits `MAX_RD_LATENCY` = 4 and `MAX_STARVE_LIMIT` = 15.
- **Sub-module `rd_tag_pipe`.** Parameterised by `RD_LATENCY`; holds the tag shift register plus the tail decode. The arbiter FSM, counter and mux stay in `mem_port_arbiter`.

## Test plan
- **A-only read.** A read at 0x0000_0010 with memory word 0xDEADBEEF → `o_a_gnt` the same cycle, `o_lsu_stall` = 0. `o_a_rvalid` = 1 with 0xDEADBEEF one cycle later; `o_b_rvalid` stays 0.
- **Starvation guard.** A and B both request every cycle, `STARVE_LIMIT` = 4 → the grant sequence is A,A,A,A,B,A,A,A,A,B. `o_lsu_stall` = 1 exactly in the B cycles.
- **Lock.** B writes 0x1234_5678 with `i_b_lock` = 1 while A requests continuously → `o_locked` from the next cycle, and A is stalled every cycle. Dropping `i_b_lock` → exactly one more B-priority cycle, then A is granted.
- **Mixed reads.** Reads A@0x100, B@0x104, A@0x108 on consecutive cycles, `RD_LATENCY` = 2 → rvalids A, B, A on cycles 2, 3, 4 with the matching data. The non-owner rdata reads 0.
- **Write byte enables.** A write with be = 4'b0100 → `o_m_be` = 4'b0100. An A read with `i_a_be` = 4'b1111 → `o_m_be` = 4'b0000.
- **Reset mid-flight.** Assert `i_reset` = 0 the cycle after a granted read → no rvalid ever appears. After release: `o_locked` = 0, `starve_cnt` = 0, and the first simultaneous request grants A.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the MEM-stage memory port arbiter.
//   owner_e     : which requester owns an issued access (LSU = A, debug/loader = B)
//   arb_state_e : arbiter FSM states
//   rd_tag_t    : one slot of the read-return tag pipeline
package mem_arb_pkg;

    localparam int MAX_RD_LATENCY   = 4;
    localparam int MAX_STARVE_LIMIT = 15;
    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int BE_W             = 4;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef enum logic {
        ARB    = 1'b0,
        LOCK_B = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around the memory port arbiter.
//   i_a_* / o_a_* : LSU requester side
//   i_b_* / o_b_* : debug / program-loader requester side (plus i_b_lock)
//   o_m_* / i_m_* : downstream DMEM + I/O decode side
//   o_lsu_stall, o_locked : status back to the pipeline
// Modport slave is the arbiter's view; master is the surrounding environment.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_a_req;
    logic              i_a_we;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] i_a_wdata;
    logic [BE_W-1:0]   i_a_be;
    logic              o_a_gnt;
    logic              o_a_rvalid;
    logic [DATA_W-1:0] o_a_rdata;

    logic              i_b_req;
    logic              i_b_we;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] i_b_wdata;
    logic [BE_W-1:0]   i_b_be;
    logic              i_b_lock;
    logic              o_b_gnt;
    logic              o_b_rvalid;
    logic [DATA_W-1:0] o_b_rdata;

    logic              o_m_req;
    logic              o_m_we;
    logic [ADDR_W-1:0] o_m_addr;
    logic [DATA_W-1:0] o_m_wdata;
    logic [BE_W-1:0]   o_m_be;
    logic [DATA_W-1:0] i_m_rdata;

    logic              o_lsu_stall;
    logic              o_locked;

    modport master (
        output i_a_req, i_a_we, i_a_addr, i_a_wdata, i_a_be,
        output i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be, i_b_lock,
        output i_m_rdata,
        input  o_a_gnt, o_a_rvalid, o_a_rdata,
        input  o_b_gnt, o_b_rvalid, o_b_rdata,
        input  o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_be,
        input  o_lsu_stall, o_locked
    );

    modport slave (
        input  i_a_req, i_a_we, i_a_addr, i_a_wdata, i_a_be,
        input  i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be, i_b_lock,
        input  i_m_rdata,
        output o_a_gnt, o_a_rvalid, o_a_rdata,
        output o_b_gnt, o_b_rvalid, o_b_rdata,
        output o_m_req, o_m_we, o_m_addr, o_m_wdata, o_m_be,
        output o_lsu_stall, o_locked
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipeline. One tag is pushed every cycle; the tag reaching
// the tail RD_LATENCY cycles later says whether the downstream read data on
// i_m_rdata belongs to port A, port B, or nobody.
//   i_clk, i_reset   : clock, synchronous active-low reset
//   i_tag            : tag of the access issued this cycle
//   i_m_rdata        : downstream read data
//   o_a_rvalid/rdata : port A read return (rdata is 0 when not valid)
//   o_b_rvalid/rdata : port B read return (rdata is 0 when not valid)
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  rd_tag_t           i_tag,
    input  logic [DATA_W-1:0] i_m_rdata,
    output logic              o_a_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_b_rdata
);

    // Out-of-range latencies are clamped so the shift register stays sane.
    localparam int DEPTH = (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                           ((RD_LATENCY < 1) ? 1 : RD_LATENCY);

    rd_tag_t tag_q [DEPTH];
    rd_tag_t tag_d [DEPTH];
    rd_tag_t tail;

    always_comb begin
        tag_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Reset invalidates every slot so reads in flight at reset never return.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign tail = tag_q[DEPTH-1];

    // Gating with i_reset keeps returns quiet for the whole reset window,
    // including the first reset cycle before the slots have been cleared.
    assign o_a_rvalid = i_reset & tail.valid & (tail.owner == OWN_A);
    assign o_b_rvalid = i_reset & tail.valid & (tail.owner == OWN_B);
    assign o_a_rdata  = o_a_rvalid ? i_m_rdata : '0;
    assign o_b_rdata  = o_b_rvalid ? i_m_rdata : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single MEM-stage data-memory/I/O port between the LSU
// (port A, normally preferred) and the debug/program-loader (port B, which
// gets a starvation guard and an exclusive lock mode). Issues at most one
// access per cycle with zero-latency grant and routes read data back to the
// owner through rd_tag_pipe.
//   i_clk   : clock
//   i_reset : synchronous active-low reset
//   bus     : mem_port_arbiter_if.slave, requester / downstream / status signals
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int RD_LATENCY   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'((STARVE_LIMIT > MAX_STARVE_LIMIT) ? MAX_STARVE_LIMIT :
                                      ((STARVE_LIMIT < 1) ? 1 : STARVE_LIMIT));

    arb_state_e        state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              a_gnt, b_gnt;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [BE_W-1:0]   m_be;
    rd_tag_t           push_tag;
    logic              a_rvalid, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= ARB;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant decision and next state. Nothing is granted while in reset.
    always_comb begin
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (i_reset) begin
            unique case (state_q)
                ARB: begin
                    // A normally wins; B wins once it has watched LIMIT A-grants in a row.
                    if (bus.i_b_req && (starve_cnt_q == LIMIT)) begin
                        b_gnt = 1'b1;
                    end else if (bus.i_a_req) begin
                        a_gnt = 1'b1;
                    end else if (bus.i_b_req) begin
                        b_gnt = 1'b1;
                    end
                    if (b_gnt || !bus.i_b_req) begin
                        starve_cnt_d = '0;
                    end else if (a_gnt && (starve_cnt_q < LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                    if (b_gnt && bus.i_b_lock) begin
                        state_d = LOCK_B;
                    end
                end
                LOCK_B: begin
                    // B keeps exclusive priority even in the cycle the lock drops.
                    b_gnt = bus.i_b_req;
                    if (!bus.i_b_lock) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    // Downstream mux: the granted port's fields, all-zero when idle.
    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        if (b_gnt) begin
            m_we    = bus.i_b_we;
            m_addr  = bus.i_b_addr;
            m_wdata = bus.i_b_wdata;
            m_be    = bus.i_b_be;
        end else if (a_gnt) begin
            m_we    = bus.i_a_we;
            m_addr  = bus.i_a_addr;
            m_wdata = bus.i_a_wdata;
            m_be    = bus.i_a_be;
        end
    end

    assign push_tag.valid = (a_gnt | b_gnt) & ~m_we;
    assign push_tag.owner = b_gnt ? OWN_B : OWN_A;

    rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_tag_pipe (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tag      (push_tag),
        .i_m_rdata  (bus.i_m_rdata),
        .o_a_rvalid (a_rvalid),
        .o_a_rdata  (a_rdata),
        .o_b_rvalid (b_rvalid),
        .o_b_rdata  (b_rdata)
    );

    assign bus.o_a_gnt     = a_gnt;
    assign bus.o_b_gnt     = b_gnt;
    assign bus.o_m_req     = a_gnt | b_gnt;
    assign bus.o_m_we      = m_we;
    assign bus.o_m_addr    = m_addr;
    assign bus.o_m_wdata   = m_wdata;
    // Byte enables are meaningless on reads, so they never leave the block.
    assign bus.o_m_be      = m_we ? m_be : '0;
    assign bus.o_a_rvalid  = a_rvalid;
    assign bus.o_a_rdata   = a_rdata;
    assign bus.o_b_rvalid  = b_rvalid;
    assign bus.o_b_rdata   = b_rdata;
    assign bus.o_lsu_stall = i_reset & bus.i_a_req & ~a_gnt;
    assign bus.o_locked    = (state_q == LOCK_B);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (STARVE_LIMIT=4, RD_LATENCY=2).
// Directed stimulus checks grants/mux/status directly; read returns are
// pushed as expectations into a queue and consumed by an independent monitor.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int RD_LAT = 2;
    localparam int STARVE = 4;

    typedef struct {
        owner_e      owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc   = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        expq[$];
    exp_t        mon_e;
    logic [31:0] mem_pipe [RD_LAT];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_LIMIT (STARVE),
        .RD_LATENCY   (RD_LAT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Fixed memory contents, independent of the DUT.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0000_0010) return 32'hDEAD_BEEF;
        return 32'hA5A5_0000 | {16'h0, addr[15:0]};
    endfunction

    // Downstream memory: read data shows up RD_LAT cycles after the issue cycle.
    initial begin
        for (int i = 0; i < RD_LAT; i++) mem_pipe[i] = 32'h0;
    end

    always @(posedge clk) begin
        mem_pipe[0] <= (bus.o_m_req && !bus.o_m_we) ? memWord(bus.o_m_addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < RD_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end

    assign bus.i_m_rdata = mem_pipe[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkGrants(input string tag, input logic ea, input logic eb, input logic es);
        checkOutput({tag, ".a_gnt"}, {31'h0, bus.o_a_gnt}, {31'h0, ea});
        checkOutput({tag, ".b_gnt"}, {31'h0, bus.o_b_gnt}, {31'h0, eb});
        checkOutput({tag, ".lsu_stall"}, {31'h0, bus.o_lsu_stall}, {31'h0, es});
        checkOutput({tag, ".m_req"}, {31'h0, bus.o_m_req}, {31'h0, ea | eb});
    endtask

    task automatic applyStimulus(input logic a_req, input logic a_we, input logic [31:0] a_addr,
                                 input logic [31:0] a_wdata, input logic [3:0] a_be,
                                 input logic b_req, input logic b_we, input logic [31:0] b_addr,
                                 input logic [31:0] b_wdata, input logic [3:0] b_be, input logic b_lock);
        @(negedge clk);
        bus.i_a_req   = a_req;
        bus.i_a_we    = a_we;
        bus.i_a_addr  = a_addr;
        bus.i_a_wdata = a_wdata;
        bus.i_a_be    = a_be;
        bus.i_b_req   = b_req;
        bus.i_b_we    = b_we;
        bus.i_b_addr  = b_addr;
        bus.i_b_wdata = b_wdata;
        bus.i_b_be    = b_be;
        bus.i_b_lock  = b_lock;
        #2;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic bothWrite(input logic b_lock);
        applyStimulus(1'b1, 1'b1, 32'h48, 32'h3, 4'hF, 1'b1, 1'b1, 32'h4C, 32'h1234_5678, 4'hF, b_lock);
    endtask

    task automatic expectRead(input owner_e owner, input logic [31:0] data);
        expq.push_back('{owner, data, cyc + RD_LAT});
    endtask

    // Read-return monitor: compares every returned word against the queue.
    always @(posedge clk) begin
        #1;
        while (expq.size() > 0 && expq[0].due < cyc) begin
            mon_e = expq.pop_front();
            checkOutput("missed_rvalid", 32'h0, mon_e.data);
        end
        if (bus.o_a_rvalid && bus.o_b_rvalid) begin
            checkOutput("dual_rvalid", 32'h1, 32'h0);
        end else if (bus.o_a_rvalid || bus.o_b_rvalid) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_rvalid", 32'h1, 32'h0);
            end else begin
                mon_e = expq.pop_front();
                checkOutput("rvalid_owner", bus.o_b_rvalid ? 32'h1 : 32'h0, (mon_e.owner == OWN_B) ? 32'h1 : 32'h0);
                checkOutput("rvalid_cycle", cyc, mon_e.due);
                checkOutput("rdata", bus.o_b_rvalid ? bus.o_b_rdata : bus.o_a_rdata, mon_e.data);
                checkOutput("nonowner_rdata", bus.o_b_rvalid ? bus.o_a_rdata : bus.o_b_rdata, 32'h0);
            end
        end else begin
            checkOutput("idle_a_rdata", bus.o_a_rdata, 32'h0);
            checkOutput("idle_b_rdata", bus.o_b_rdata, 32'h0);
        end
    end

    initial begin
        logic exp_b;

        bus.i_a_req = 1'b0; bus.i_a_we = 1'b0; bus.i_a_addr = '0; bus.i_a_wdata = '0; bus.i_a_be = '0;
        bus.i_b_req = 1'b0; bus.i_b_we = 1'b0; bus.i_b_addr = '0; bus.i_b_wdata = '0; bus.i_b_be = '0;
        bus.i_b_lock = 1'b0;

        // Reset with both ports requesting: everything must stay quiet.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b1);
        checkGrants("reset0", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b1);
        checkGrants("reset1", 1'b0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b1;
        checkOutput("reset.locked", {31'h0, bus.o_locked}, 32'h0);

        // A-only read.
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checkGrants("a_read", 1'b1, 1'b0, 1'b0);
        checkOutput("a_read.m_addr", bus.o_m_addr, 32'h10);
        checkOutput("a_read.m_we", {31'h0, bus.o_m_we}, 32'h0);
        checkOutput("a_read.m_be", {28'h0, bus.o_m_be}, 32'h0);
        expectRead(OWN_A, 32'hDEAD_BEEF);
        repeat (3) idle();

        // A write with a single byte lane.
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h55AA_55AA, 4'b0100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checkGrants("a_write", 1'b1, 1'b0, 1'b0);
        checkOutput("a_write.m_we", {31'h0, bus.o_m_we}, 32'h1);
        checkOutput("a_write.m_be", {28'h0, bus.o_m_be}, 32'h4);
        checkOutput("a_write.m_wdata", bus.o_m_wdata, 32'h55AA_55AA);
        idle();

        // Mixed-owner back-to-back reads.
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checkGrants("mix0", 1'b1, 1'b0, 1'b0);
        expectRead(OWN_A, 32'hA5A5_0100);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0);
        checkGrants("mix1", 1'b0, 1'b1, 1'b0);
        checkOutput("mix1.m_addr", bus.o_m_addr, 32'h104);
        expectRead(OWN_B, 32'hA5A5_0104);
        applyStimulus(1'b1, 1'b0, 32'h108, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        checkGrants("mix2", 1'b1, 1'b0, 1'b0);
        expectRead(OWN_A, 32'hA5A5_0108);
        repeat (4) idle();

        // Lock without request does nothing in ARB.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkGrants("lock_noreq", 1'b0, 1'b0, 1'b0);
        idle();
        checkOutput("lock_noreq.locked", {31'h0, bus.o_locked}, 32'h0);

        // Starvation guard: A,A,A,A,B repeating.
        for (int i = 0; i < 10; i++) begin
            bothWrite(1'b0);
            exp_b = ((i % 5) == 4);
            checkGrants($sformatf("starve%0d", i), !exp_b, exp_b, exp_b);
        end
        idle();

        // Lock: B gets in through the starvation guard, then owns the port.
        for (int i = 0; i < 5; i++) begin
            bothWrite(1'b1);
            checkGrants($sformatf("lock_wait%0d", i), i != 4, i == 4, i == 4);
        end
        checkOutput("lock.m_wdata", bus.o_m_wdata, 32'h1234_5678);
        applyStimulus(1'b1, 1'b1, 32'h48, 32'h3, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("lock.locked", {31'h0, bus.o_locked}, 32'h1);
        checkGrants("lock_held_noreq", 1'b0, 1'b0, 1'b1);
        bothWrite(1'b1);
        checkGrants("lock_b", 1'b0, 1'b1, 1'b1);
        bothWrite(1'b0);
        checkGrants("lock_exit", 1'b0, 1'b1, 1'b1);
        checkOutput("lock_exit.locked", {31'h0, bus.o_locked}, 32'h1);
        bothWrite(1'b0);
        checkGrants("lock_after", 1'b1, 1'b0, 1'b0);
        checkOutput("lock_after.locked", {31'h0, bus.o_locked}, 32'h0);
        idle();

        // Reset while locked with a B read in flight.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b1);
        checkGrants("rst_lock", 1'b0, 1'b1, 1'b0);
        idle();
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
        checkOutput("rst_lock.locked", {31'h0, bus.o_locked}, 32'h0);

        // Reset with starve count at 3 and an A read in flight.
        for (int i = 0; i < 3; i++) begin
            if (i == 2)
                applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1, 1'b1, 32'h4C, 32'h9, 4'hF, 1'b0);
            else
                bothWrite(1'b0);
            checkGrants($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 1'b0);
        end
        bothWrite(1'b0);
        rst_n = 1'b0;
        bothWrite(1'b0);
        checkGrants("rst_hold", 1'b0, 1'b0, 1'b0);
        bothWrite(1'b0);
        rst_n = 1'b1;
        #1;
        checkGrants("post_rst0", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            bothWrite(1'b0);
            checkGrants($sformatf("post_rst%0d", i), i != 4, i == 4, i == 4);
        end

        repeat (6) idle();
        checkOutput("queue_empty", expq.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
